// File: rtl/cpu_pkg.sv
// Shared CPU definitions: B-operand source encoding and default datapath width.
package cpu_pkg;

  localparam int CPU_DATA_W = 8;

  typedef enum logic [1:0] {
    BSEL_REG  = 2'b00,
    BSEL_IMM  = 2'b01,
    BSEL_LAST = 2'b10,
    BSEL_SW   = 2'b11
  } b_sel_e;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus stability-count debouncer for a bank of switch inputs.
module sw_debounce #(
  parameter int W            = 8,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw,
  output logic [W-1:0] value,
  output logic         changed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);

  if (DEBOUNCE_CYC < 1) begin : g_bad_cyc
    $error("sw_debounce: DEBOUNCE_CYC must be at least 1");
  end

  logic [W-1:0]     sync1_q, sync2_q;
  logic [W-1:0]     cand_q, cand_d;
  logic [W-1:0]     value_q, value_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
  logic             changed_q, changed_d;

  // The candidate restarts the count at 1; reaching the limit accepts it at once.
  always_comb begin
    cand_d    = cand_q;
    value_d   = value_q;
    cnt_d     = cnt_q;
    cnt_nxt   = '0;
    changed_d = 1'b0;
    if (sync2_q == value_q) begin
      cnt_d = '0;
    end else begin
      if (sync2_q != cand_q) begin
        cand_d  = sync2_q;
        cnt_nxt = CNT_W'(1);
      end else begin
        cnt_nxt = cnt_q + CNT_W'(1);
      end
      if (cnt_nxt == CNT_MAX) begin
        value_d   = sync2_q;
        cnt_d     = '0;
        changed_d = 1'b1;
      end else begin
        cnt_d = cnt_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      value_q   <= '0;
      cnt_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      cand_q    <= cand_d;
      value_q   <= value_d;
      cnt_q     <= cnt_d;
      changed_q <= changed_d;
    end
  end

  assign value   = value_q;
  assign changed = changed_q;

endmodule

// File: rtl/b_operand_sel.sv
// Registered ALU B-operand selector with valid/stall hold and debounced switch source.
module b_operand_sel
  import cpu_pkg::*;
#(
  parameter int DATA_W       = CPU_DATA_W,
  parameter int IMM_W        = 4,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        b_sel,
  input  logic              sel_valid,
  input  logic              stall,
  input  logic [DATA_W-1:0] b_data,
  input  logic [IMM_W-1:0]  imm,
  input  logic              imm_signed,
  input  logic [DATA_W-1:0] in_switch,
  output logic [DATA_W-1:0] b_bus,
  output logic              b_valid,
  output logic [DATA_W-1:0] sw_value,
  output logic              sw_changed
);

  if (IMM_W > DATA_W || IMM_W < 1) begin : g_bad_imm
    $error("b_operand_sel: IMM_W must be in 1..DATA_W");
  end

  logic [DATA_W-1:0] b_bus_q, b_bus_d;
  logic              b_valid_q, b_valid_d;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] src;
  b_sel_e            sel;

  sw_debounce #(
    .W            (DATA_W),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_sw_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw     (in_switch),
    .value   (sw_value),
    .changed (sw_changed)
  );

  always_comb begin
    imm_ext = '0;
    imm_ext[IMM_W-1:0] = imm;
    for (int i = IMM_W; i < DATA_W; i++) begin
      imm_ext[i] = imm_signed & imm[IMM_W-1];
    end
  end

  // Switch source takes the already-registered debounced value, never the in-flight update.
  assign sel = b_sel_e'(b_sel);

  always_comb begin
    src = b_bus_q;
    case (sel)
      BSEL_REG:  src = b_data;
      BSEL_IMM:  src = imm_ext;
      BSEL_LAST: src = b_bus_q;
      BSEL_SW:   src = sw_value;
      default:   src = b_bus_q;
    endcase
  end

  always_comb begin
    b_bus_d   = b_bus_q;
    b_valid_d = b_valid_q;
    if (!stall) begin
      b_valid_d = sel_valid;
      if (sel_valid) begin
        b_bus_d = src;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_bus_q   <= '0;
      b_valid_q <= 1'b0;
    end else begin
      b_bus_q   <= b_bus_d;
      b_valid_q <= b_valid_d;
    end
  end

  assign b_bus   = b_bus_q;
  assign b_valid = b_valid_q;

endmodule

// File: tb/tb_b_operand_sel.sv
// Directed table-driven bench for b_operand_sel, plus switch debounce and async reset sequences.
module tb_b_operand_sel;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] b_sel;
  logic       sel_valid;
  logic       stall;
  logic [7:0] b_data;
  logic [3:0] imm;
  logic       imm_signed;
  logic [7:0] in_switch;
  logic [7:0] b_bus;
  logic       b_valid;
  logic [7:0] sw_value;
  logic       sw_changed;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  b_operand_sel #(
    .DATA_W       (8),
    .IMM_W        (4),
    .DEBOUNCE_CYC (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .b_sel      (b_sel),
    .sel_valid  (sel_valid),
    .stall      (stall),
    .b_data     (b_data),
    .imm        (imm),
    .imm_signed (imm_signed),
    .in_switch  (in_switch),
    .b_bus      (b_bus),
    .b_valid    (b_valid),
    .sw_value   (sw_value),
    .sw_changed (sw_changed)
  );

  typedef struct {
    logic [1:0] sel;
    logic       valid;
    logic       stl;
    logic [7:0] data;
    logic [3:0] immv;
    logic       imm_s;
    logic [7:0] exp_bus;
    logic       exp_valid;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b_sel      = 2'b00;
    sel_valid  = 1'b0;
    stall      = 1'b0;
    b_data     = 8'h00;
    imm        = 4'h0;
    imm_signed = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    //               sel    v     stl   data   imm   s     bus    valid
    tbl[0]  = '{2'b00, 1'b1, 1'b0, 8'h5A, 4'h0, 1'b0, 8'h5A, 1'b1};
    tbl[1]  = '{2'b00, 1'b0, 1'b0, 8'hEE, 4'h0, 1'b0, 8'h5A, 1'b0};
    tbl[2]  = '{2'b01, 1'b1, 1'b0, 8'h00, 4'hA, 1'b0, 8'h0A, 1'b1};
    tbl[3]  = '{2'b01, 1'b1, 1'b0, 8'h00, 4'hA, 1'b1, 8'hFA, 1'b1};
    tbl[4]  = '{2'b01, 1'b1, 1'b0, 8'h00, 4'h7, 1'b1, 8'h07, 1'b1};
    tbl[5]  = '{2'b00, 1'b1, 1'b0, 8'h33, 4'h0, 1'b0, 8'h33, 1'b1};
    tbl[6]  = '{2'b00, 1'b1, 1'b1, 8'h44, 4'h0, 1'b0, 8'h33, 1'b1};
    tbl[7]  = '{2'b00, 1'b1, 1'b1, 8'h44, 4'h0, 1'b0, 8'h33, 1'b1};
    tbl[8]  = '{2'b00, 1'b1, 1'b1, 8'h44, 4'h0, 1'b0, 8'h33, 1'b1};
    tbl[9]  = '{2'b00, 1'b1, 1'b0, 8'h44, 4'h0, 1'b0, 8'h44, 1'b1};
    tbl[10] = '{2'b10, 1'b1, 1'b0, 8'h99, 4'h3, 1'b1, 8'h44, 1'b1};
    tbl[11] = '{2'b00, 1'b0, 1'b0, 8'h12, 4'h0, 1'b0, 8'h44, 1'b0};
    tbl[12] = '{2'b00, 1'b1, 1'b1, 8'h55, 4'h0, 1'b0, 8'h44, 1'b0};

    idle_inputs();
    in_switch = 8'h00;
    rst_n     = 1'b0;
    #12;
    check("reset_b_bus", b_bus, 8'h00);
    check("reset_b_valid", {7'b0, b_valid}, 8'h00);
    check("reset_sw_value", sw_value, 8'h00);
    check("reset_sw_changed", {7'b0, sw_changed}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Operand path vectors
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      b_sel      = tbl[i].sel;
      sel_valid  = tbl[i].valid;
      stall      = tbl[i].stl;
      b_data     = tbl[i].data;
      imm        = tbl[i].immv;
      imm_signed = tbl[i].imm_s;
      tick();
      check($sformatf("vec%0d_b_bus", i), b_bus, tbl[i].exp_bus);
      check($sformatf("vec%0d_b_valid", i), {7'b0, b_valid}, {7'b0, tbl[i].exp_valid});
    end
    idle_inputs();

    // Steady switch value: set just after an edge, so the next edge is k
    tick();
    in_switch = 8'h81;
    for (int e = 0; e <= 4; e++) begin
      if (e == 4) begin
        b_sel     = 2'b11;
        sel_valid = 1'b1;
      end
      tick();
      check($sformatf("sw_k+%0d_value", e), sw_value, 8'h00);
      check($sformatf("sw_k+%0d_changed", e), {7'b0, sw_changed}, 8'h00);
    end
    tick();
    check("sw_k+5_value", sw_value, 8'h81);
    check("sw_k+5_changed", {7'b0, sw_changed}, 8'h01);
    check("sw_select_pre_update", b_bus, 8'h00);
    tick();
    check("sw_k+6_changed", {7'b0, sw_changed}, 8'h00);
    check("sw_select_post_update", b_bus, 8'h81);
    idle_inputs();

    // Replay immediately after reset
    in_switch = 8'h00;
    do_reset();
    b_sel     = 2'b10;
    sel_valid = 1'b1;
    tick();
    check("replay_after_reset_bus", b_bus, 8'h00);
    check("replay_after_reset_valid", {7'b0, b_valid}, 8'h01);
    idle_inputs();

    // Bouncing switch never settles long enough
    for (int c = 0; c < 20; c++) begin
      in_switch = ((c / 2) % 2 == 0) ? 8'h01 : 8'h00;
      tick();
      check($sformatf("bounce%0d", c), {sw_value[7:1], sw_value[0] | sw_changed}, 8'h00);
    end
    in_switch = 8'h00;
    repeat (4) tick();

    // Async reset in the middle of a debounce
    b_sel     = 2'b00;
    b_data    = 8'h77;
    sel_valid = 1'b1;
    tick();
    idle_inputs();
    in_switch = 8'h81;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_b_bus", b_bus, 8'h00);
    check("async_rst_b_valid", {7'b0, b_valid}, 8'h00);
    check("async_rst_sw_value", sw_value, 8'h00);
    check("async_rst_sw_changed", {7'b0, sw_changed}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("post_rst_e%0d_value", e), sw_value, (e >= 6) ? 8'h81 : 8'h00);
      check($sformatf("post_rst_e%0d_changed", e), {7'b0, sw_changed}, (e == 6) ? 8'h01 : 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
